// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: BCD digit limits, default prescale and BCD helpers.
// Also consumed by the 7-segment display driver.
package stopwatch_pkg;

  localparam int unsigned BCD_W            = 4;
  localparam int unsigned TICK_DIV_DEFAULT = 100_000_000;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t SEC_ONES_MAX = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_ONES_MAX = 4'd9;
  localparam bcd_t MIN_TENS_MAX = 4'd5;

  // Next value of a digit on advance; anything at or above max folds back to zero.
  function automatic bcd_t bcd_next(input bcd_t q, input bcd_t max);
    bcd_t nxt;
    if (q >= max) begin
      nxt = 4'd0;
    end else begin
      nxt = q + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit of the stopwatch carry chain, counting 0..MAX.
// Advances only while inc is high; carry_out flags the reload back to zero.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry_out
);

  logic [3:0] q_r;

  // Digit register: reset and clear take priority over an advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= 4'd0;
    end else if (clr) begin
      q_r <= 4'd0;
    end else if (inc) begin
      q_r <= bcd_next(q_r, MAX);
    end else begin
      q_r <= q_r;
    end
  end

  assign q         = q_r;
  assign carry_out = inc & (q_r == MAX);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping datapath: prescaler to a 1 s tick feeding an MM:SS BCD chain.
// All outputs come straight from registers.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned PRE_W    = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_regs,
  input  logic        count_enabled,
  output logic [15:0] time_reading,
  output logic        sec_tick,
  output logic        wrapped
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_r;
  logic             tick_s;
  logic             sec_tick_r;
  logic             wrapped_r;
  logic [3:0]       sec_ones_s, sec_tens_s, min_ones_s, min_tens_s;
  logic             c_sec_ones_s, c_sec_tens_s, c_min_ones_s, c_min_tens_s;

  // Second tick: last prescaler cycle while counting and not being cleared.
  always_comb begin
    tick_s = 1'b0;
    if (count_enabled && !init_regs && (pre_r == PRE_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Prescaler: holds its partial second while paused.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_r <= '0;
    end else if (init_regs) begin
      pre_r <= '0;
    end else if (count_enabled) begin
      if (pre_r == PRE_LAST) begin
        pre_r <= '0;
      end else begin
        pre_r <= pre_r + PRE_W'(1'b1);
      end
    end else begin
      pre_r <= pre_r;
    end
  end

  // Status flags: one-cycle tick pulse and sticky wrap from the top digit's carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      sec_tick_r <= 1'b0;
      wrapped_r  <= 1'b0;
    end else if (init_regs) begin
      sec_tick_r <= 1'b0;
      wrapped_r  <= 1'b0;
    end else begin
      sec_tick_r <= tick_s;
      wrapped_r  <= wrapped_r | c_min_tens_s;
    end
  end

  bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk(clk), .reset(reset), .clr(init_regs), .inc(tick_s),
    .q(sec_ones_s), .carry_out(c_sec_ones_s)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .reset(reset), .clr(init_regs), .inc(c_sec_ones_s),
    .q(sec_tens_s), .carry_out(c_sec_tens_s)
  );

  bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .clk(clk), .reset(reset), .clr(init_regs), .inc(c_sec_tens_s),
    .q(min_ones_s), .carry_out(c_min_ones_s)
  );

  bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk(clk), .reset(reset), .clr(init_regs), .inc(c_min_ones_s),
    .q(min_tens_s), .carry_out(c_min_tens_s)
  );

  assign time_reading = {min_tens_s, min_ones_s, sec_tens_s, sec_ones_s};
  assign sec_tick     = sec_tick_r;
  assign wrapped      = wrapped_r;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter with TICK_DIV = 4.
module tb_stopwatch_counter;

  logic        clk;
  logic        reset;
  logic        init_regs;
  logic        count_enabled;
  logic [15:0] time_reading;
  logic        sec_tick;
  logic        wrapped;

  int n_cmp;
  int n_fail;

  stopwatch_counter #(.TICK_DIV(4), .PRE_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .init_regs(init_regs),
    .count_enabled(count_enabled),
    .time_reading(time_reading),
    .sec_tick(sec_tick),
    .wrapped(wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_regs();
    init_regs = 1'b1;
    count_enabled = 1'b0;
    step();
    init_regs = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    init_regs = 1'b0;
    count_enabled = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (time_reading !== 16'h0000) begin
        n_fail++; $display("FAIL reset_reading cyc %0d: got %h expected 0000", i, time_reading);
      end
      n_cmp++;
      if (sec_tick !== 1'b0) begin
        n_fail++; $display("FAIL reset_tick cyc %0d: got %b expected 0", i, sec_tick);
      end
      n_cmp++;
      if (wrapped !== 1'b0) begin
        n_fail++; $display("FAIL reset_wrapped cyc %0d: got %b expected 0", i, wrapped);
      end
    end
    reset = 1'b0;
    count_enabled = 1'b0;
  endtask

  task automatic test_count();
    int pulses;
    pulses = 0;
    count_enabled = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (sec_tick === 1'b1) pulses++;
      n_cmp++;
      if (sec_tick !== ((i % 4) == 0)) begin
        n_fail++; $display("FAIL count_tick cyc %0d: got %b expected %b", i, sec_tick, (i % 4) == 0);
      end
    end
    count_enabled = 1'b0;
    n_cmp++;
    if (pulses != 10) begin
      n_fail++; $display("FAIL count_pulses: got %0d expected 10", pulses);
    end
    n_cmp++;
    if (time_reading !== 16'h0010) begin
      n_fail++; $display("FAIL count_reading: got %h expected 0010", time_reading);
    end
  endtask

  task automatic test_pause();
    clear_regs();
    count_enabled = 1'b1;
    run(2);
    count_enabled = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      n_cmp++;
      if (time_reading !== 16'h0000 || sec_tick !== 1'b0) begin
        n_fail++; $display("FAIL pause_hold cyc %0d: got %h/%b expected 0000/0", i, time_reading, sec_tick);
      end
    end
    count_enabled = 1'b1;
    step();
    n_cmp++;
    if (time_reading !== 16'h0000 || sec_tick !== 1'b0) begin
      n_fail++; $display("FAIL pause_resume1: got %h/%b expected 0000/0", time_reading, sec_tick);
    end
    step();
    count_enabled = 1'b0;
    n_cmp++;
    if (time_reading !== 16'h0001 || sec_tick !== 1'b1) begin
      n_fail++; $display("FAIL pause_resume2: got %h/%b expected 0001/1", time_reading, sec_tick);
    end
  endtask

  task automatic test_carry();
    clear_regs();
    count_enabled = 1'b1;
    run(59 * 4);
    n_cmp++;
    if (time_reading !== 16'h0059) begin
      n_fail++; $display("FAIL carry_preload: got %h expected 0059", time_reading);
    end
    run(4);
    count_enabled = 1'b0;
    n_cmp++;
    if (time_reading !== 16'h0100 || wrapped !== 1'b0) begin
      n_fail++; $display("FAIL carry_minute: got %h/%b expected 0100/0", time_reading, wrapped);
    end
  endtask

  task automatic test_wrap();
    clear_regs();
    count_enabled = 1'b1;
    run(3599 * 4);
    n_cmp++;
    if (time_reading !== 16'h5959 || wrapped !== 1'b0) begin
      n_fail++; $display("FAIL wrap_preload: got %h/%b expected 5959/0", time_reading, wrapped);
    end
    run(4);
    n_cmp++;
    if (time_reading !== 16'h0000 || wrapped !== 1'b1 || sec_tick !== 1'b1) begin
      n_fail++; $display("FAIL wrap_roll: got %h/%b/%b expected 0000/1/1", time_reading, wrapped, sec_tick);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++;
      if (wrapped !== 1'b1) begin
        n_fail++; $display("FAIL wrap_sticky cyc %0d: got %b expected 1", i, wrapped);
      end
    end
    count_enabled = 1'b0;
    n_cmp++;
    if (time_reading !== 16'h0002) begin
      n_fail++; $display("FAIL wrap_after: got %h expected 0002", time_reading);
    end
  endtask

  // Continues from 00:02 with wrapped still set, prescaler at 0.
  task automatic test_init_both();
    count_enabled = 1'b1;
    run(81 * 4 + 2);
    n_cmp++;
    if (time_reading !== 16'h0123 || wrapped !== 1'b1) begin
      n_fail++; $display("FAIL init_preload: got %h/%b expected 0123/1", time_reading, wrapped);
    end
    init_regs = 1'b1;
    step();
    init_regs = 1'b0;
    n_cmp++;
    if (time_reading !== 16'h0000 || wrapped !== 1'b0 || sec_tick !== 1'b0) begin
      n_fail++; $display("FAIL init_clear: got %h/%b/%b expected 0000/0/0", time_reading, wrapped, sec_tick);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++;
      if (sec_tick !== (i == 4) || time_reading !== ((i == 4) ? 16'h0001 : 16'h0000)) begin
        n_fail++; $display("FAIL init_restart cyc %0d: got %h/%b expected %h/%b", i, time_reading, sec_tick,
                           (i == 4) ? 16'h0001 : 16'h0000, i == 4);
      end
    end
    count_enabled = 1'b0;
  endtask

  task automatic test_reset_on_tick();
    clear_regs();
    count_enabled = 1'b1;
    run(9 * 4 + 3);
    n_cmp++;
    if (time_reading !== 16'h0009) begin
      n_fail++; $display("FAIL rtick_preload: got %h expected 0009", time_reading);
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if (time_reading !== 16'h0000 || sec_tick !== 1'b0 || wrapped !== 1'b0) begin
      n_fail++; $display("FAIL rtick_clear: got %h/%b/%b expected 0000/0/0", time_reading, sec_tick, wrapped);
    end
    reset = 1'b0;
    count_enabled = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    init_regs = 1'b0;
    count_enabled = 1'b0;
    test_reset();
    test_count();
    test_pause();
    test_carry();
    test_wrap();
    test_init_both();
    test_reset_on_tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
